// File: rtl/fas_pkg.sv
// Shared definitions for the FFT output serializer: frame geometry, bin word layout
// and the 4-bit bit-reversal used to put bins back into natural order.
package fas_pkg;

    localparam int unsigned FFT_N = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned BIN_W = 32;

    typedef logic [IDX_W-1:0] idx_t;

    typedef struct packed {
        logic [BIN_W/2-1:0] re;
        logic [BIN_W/2-1:0] im;
    } bin_t;

    function automatic idx_t bitrev4(input idx_t k);
        return {k[0], k[1], k[2], k[3]};
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of storage: all 16 bins written in parallel, one bin read by index.
module fft_frame_bank
    import fas_pkg::*;
#(
    parameter int unsigned DW = 32
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [DW-1:0] wdata [FFT_N],
    input  idx_t          raddr,
    output logic [DW-1:0] rdata
);

    // Contents are deliberately not reset; occupancy tracking decides validity.
    logic [DW-1:0] mem_q [FFT_N];

    always_ff @(posedge CLK) begin
        if (we) begin
            for (int k = 0; k < FFT_N; k++) begin
                mem_q[k] <= wdata[k];
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fft_serializer.sv
// Ping-pong parallel-to-serial converter: captures a 16-bin FFT frame in one cycle and
// streams it out one bin per valid/ready transfer while the other bank can refill.
module fft_serializer
    import fas_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter bit          BITREV = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_d0,
    input  logic [DW-1:0]    in_d1,
    input  logic [DW-1:0]    in_d2,
    input  logic [DW-1:0]    in_d3,
    input  logic [DW-1:0]    in_d4,
    input  logic [DW-1:0]    in_d5,
    input  logic [DW-1:0]    in_d6,
    input  logic [DW-1:0]    in_d7,
    input  logic [DW-1:0]    in_d8,
    input  logic [DW-1:0]    in_d9,
    input  logic [DW-1:0]    in_d10,
    input  logic [DW-1:0]    in_d11,
    input  logic [DW-1:0]    in_d12,
    input  logic [DW-1:0]    in_d13,
    input  logic [DW-1:0]    in_d14,
    input  logic [DW-1:0]    in_d15,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_d,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last
);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e     state_q, state_d;
    logic [1:0] occ_q, occ_d;
    logic       wr_sel_q, wr_sel_d;
    logic       rd_sel_q, rd_sel_d;
    idx_t       idx_q, idx_d;

    logic [DW-1:0] in_arr [FFT_N];
    logic [DW-1:0] wr_arr [FFT_N];
    logic [DW-1:0] rdata0, rdata1;
    logic          capture, xfer, last_xfer;

    assign in_arr = '{in_d0, in_d1, in_d2, in_d3, in_d4, in_d5, in_d6, in_d7,
                      in_d8, in_d9, in_d10, in_d11, in_d12, in_d13, in_d14, in_d15};

    // Reordering happens on the write side so the read path stays a plain index.
    for (genvar k = 0; k < FFT_N; k++) begin : g_order
        if (BITREV) begin : g_rev
            assign wr_arr[k] = in_arr[bitrev4(idx_t'(k))];
        end else begin : g_nat
            assign wr_arr[k] = in_arr[k];
        end
    end

    fft_frame_bank #(.DW(DW)) u_bank0 (
        .CLK   (CLK),
        .we    (capture && !wr_sel_q),
        .wdata (wr_arr),
        .raddr (idx_q),
        .rdata (rdata0)
    );

    fft_frame_bank #(.DW(DW)) u_bank1 (
        .CLK   (CLK),
        .we    (capture && wr_sel_q),
        .wdata (wr_arr),
        .raddr (idx_q),
        .rdata (rdata1)
    );

    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (state_q == StStream);
    assign out_idx   = idx_q;
    assign out_last  = out_valid && (idx_q == 4'd15);
    assign out_d     = out_valid ? (rd_sel_q ? rdata1 : rdata0) : '0;

    assign capture   = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && (idx_q == 4'd15);

    always_comb begin
        occ_d    = occ_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        idx_d    = idx_q;
        state_d  = state_q;

        unique case ({capture, last_xfer})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        if (capture) begin
            wr_sel_d = !wr_sel_q;
        end
        if (xfer) begin
            idx_d = idx_q + 4'd1;
        end
        if (last_xfer) begin
            rd_sel_d = !rd_sel_q;
        end

        unique case (state_q)
            StIdle: begin
                if (occ_q != 2'd0) begin
                    state_d = StStream;
                end
            end
            StStream: begin
                // Keep streaming straight into the other bank if it already holds a frame.
                if (last_xfer && (occ_d == 2'd0)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= StIdle;
            occ_q    <= 2'd0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            occ_q    <= occ_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            idx_q    <= idx_d;
        end
    end

endmodule

// File: tb/tb_fft_serializer.sv
// Scoreboard bench for fft_serializer: natural-order and bit-reversed instances share
// stimulus; a negedge monitor compares every presented word against a frame-level model.
module tb_fft_serializer;
    import fas_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] din [16];

    logic        in_ready0, out_valid0, out_last0;
    logic        in_ready1, out_valid1, out_last1;
    logic [31:0] out_d0, out_d1;
    logic [3:0]  out_idx0, out_idx1;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  idx;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   occ_m;
    bit   ready_m;
    bit   cap_flag = 1'b0;

    always #5 clk = ~clk;

    fft_serializer #(.DW(32), .BITREV(1'b0)) u_dut (
        .CLK(clk), .RST(rst_n), .in_valid(in_valid),
        .in_d0(din[0]), .in_d1(din[1]), .in_d2(din[2]), .in_d3(din[3]),
        .in_d4(din[4]), .in_d5(din[5]), .in_d6(din[6]), .in_d7(din[7]),
        .in_d8(din[8]), .in_d9(din[9]), .in_d10(din[10]), .in_d11(din[11]),
        .in_d12(din[12]), .in_d13(din[13]), .in_d14(din[14]), .in_d15(din[15]),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_d(out_d0), .out_idx(out_idx0), .out_last(out_last0)
    );

    fft_serializer #(.DW(32), .BITREV(1'b1)) u_dut_br (
        .CLK(clk), .RST(rst_n), .in_valid(in_valid),
        .in_d0(din[0]), .in_d1(din[1]), .in_d2(din[2]), .in_d3(din[3]),
        .in_d4(din[4]), .in_d5(din[5]), .in_d6(din[6]), .in_d7(din[7]),
        .in_d8(din[8]), .in_d9(din[9]), .in_d10(din[10]), .in_d11(din[11]),
        .in_d12(din[12]), .in_d13(din[13]), .in_d14(din[14]), .in_d15(din[15]),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_d(out_d1), .out_idx(out_idx1), .out_last(out_last1)
    );

    function automatic int br4(input int k);
        int r = 0;
        for (int b = 0; b < 4; b++) begin
            if (((k >> b) & 1) != 0) r |= 1 << (3 - b);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: condition not reached within bound at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ramp();
        for (int k = 0; k < 16; k++) din[k] = 32'h0001_0000 * k + k;
    endtask

    task automatic set_rand();
        for (int k = 0; k < 16; k++) din[k] = $urandom;
    endtask

    task automatic drain(input string name);
        bit done = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (q.size() == 0 && !out_valid0) done = 1'b1;
        end
        if (!done) fail(name);
    endtask

    task automatic wait_idx(input logic [3:0] target, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (out_valid0 && out_idx0 == target) found = 1'b1;
        end
        if (!found) fail(name);
    endtask

    // Model: a bank frees on the last transfer of its frame, so occupancy is the number
    // of frames with at least one word still owed to the sink.
    always @(negedge clk) begin
        if (!rst_n) begin
            cap_flag = 1'b0;
        end else begin
            occ_m   = (q.size() + 15) / 16;
            ready_m = (occ_m != 2);
            check("in_ready", {31'd0, in_ready0}, {31'd0, ready_m});
            check("in_ready_br", {31'd0, in_ready1}, {31'd0, ready_m});
            if (out_valid0) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_word: got idx %0d data %h expected no word", out_idx0, out_d0);
                end else begin
                    check("out_d", out_d0, q[0].d0);
                    check("out_d_br", out_d1, q[0].d1);
                    check("out_idx", {28'd0, out_idx0}, {28'd0, q[0].idx});
                    check("out_last", {31'd0, out_last0}, {31'd0, q[0].idx == 4'd15});
                    check("out_valid_br", {31'd0, out_valid1}, 32'd1);
                    if (out_ready) void'(q.pop_front());
                end
            end else begin
                check("idle_out_d", out_d0, 32'd0);
                check("idle_out_d_br", out_d1, 32'd0);
                check("idle_out_last", {31'd0, out_last0}, 32'd0);
                check("idle_out_valid_br", {31'd0, out_valid1}, 32'd0);
            end
            cap_flag = in_valid && ready_m;
            if (cap_flag) begin
                for (int k = 0; k < 16; k++) begin
                    q.push_back('{d0: din[k], d1: din[br4(k)], idx: 4'(k)});
                end
            end
        end
    end

    initial begin
        int sent;
        bit captured;
        bin_t probe;

        set_ramp();
        #3;
        check("rst_in_ready", {31'd0, in_ready0}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        check("rst_out_d", out_d0, 32'd0);
        check("rst_out_idx", {28'd0, out_idx0}, 32'd0);
        check("rst_out_last", {31'd0, out_last0}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single frame, continuous ready: one IDLE cycle, then 16 words back to back.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_cap", {31'd0, cap_flag}, 32'd1);
        check("lat_idle", {31'd0, out_valid0}, 32'd0);
        tick();
        check("lat_valid", {31'd0, out_valid0}, 32'd1);
        check("lat_idx0", {28'd0, out_idx0}, 32'd0);
        probe = bin_t'(out_d0);
        check("lat_re0", {16'd0, probe.re}, 32'd0);
        for (int i = 0; i < 16; i++) tick();
        check("lat_done", {31'd0, out_valid0}, 32'd0);
        drain("lat_drain");

        // Two captures fill both banks, third frame held off, then bubble-free streaming.
        out_ready = 1'b0;
        set_rand();
        in_valid = 1'b1;
        tick();
        check("bb_cap1", {31'd0, cap_flag}, 32'd1);
        check("bb_ready1", {31'd0, in_ready0}, 32'd1);
        set_rand();
        tick();
        check("bb_cap2", {31'd0, cap_flag}, 32'd1);
        check("bb_ready2", {31'd0, in_ready0}, 32'd0);
        set_rand();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bb_held", {31'd0, cap_flag}, 32'd0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("bb_no_bubble", {31'd0, out_valid0}, 32'd1);
            tick();
            if (in_valid && cap_flag) in_valid = 1'b0;
        end
        check("bb_frame3_taken", {31'd0, in_valid}, 32'd0);
        in_valid = 1'b0;
        drain("bb_drain");

        // Random backpressure over four random frames.
        sent = 0;
        for (int i = 0; i < 2000 && sent < 4; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (in_valid && cap_flag) begin
                in_valid = 1'b0;
                sent++;
            end
            if (!in_valid && sent < 4 && $urandom_range(0, 1) == 1) begin
                set_rand();
                in_valid = 1'b1;
            end
        end
        check("rnd_sent", sent, 4);
        in_valid = 1'b0;
        for (int i = 0; i < 500 && q.size() != 0; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        check("rnd_empty", q.size(), 0);
        drain("rnd_drain");

        // Capture on the same edge as the final transfer of the only full bank.
        out_ready = 1'b1;
        set_rand();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_idx(4'd15, "co_wait15");
        set_rand();
        in_valid = 1'b1;
        tick();
        check("co_cap", {31'd0, cap_flag}, 32'd1);
        in_valid = 1'b0;
        check("co_valid", {31'd0, out_valid0}, 32'd1);
        check("co_idx0", {28'd0, out_idx0}, 32'd0);
        check("co_ready", {31'd0, in_ready0}, 32'd1);
        drain("co_drain");

        // Asynchronous reset mid-stream.
        set_rand();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_idx(4'd7, "rs_wait7");
        #2;
        rst_n = 1'b0;
        #1;
        check("rs_valid", {31'd0, out_valid0}, 32'd0);
        check("rs_out_d", out_d0, 32'd0);
        check("rs_out_d_br", out_d1, 32'd0);
        check("rs_in_ready", {31'd0, in_ready0}, 32'd1);
        check("rs_idx", {28'd0, out_idx0}, 32'd0);
        q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check("rs_stays_idle", {31'd0, out_valid0}, 32'd0);
        set_rand();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("rs_restart", {31'd0, out_valid0}, 32'd1);
        check("rs_restart_idx", {28'd0, out_idx0}, 32'd0);
        drain("rs_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
